pwr_down_seq: RTL
=================

# pwr_down_seq

Power-down and re-wake sequencer, the teardown counterpart to the power-up delay generator. On a shutdown request it removes the downstream enable and waits for the downstream logic to drain, with a timeout. It then waits a settle time in RTC ticks and asserts reset to the downstream logic. When the request is withdrawn it re-sequences wake-up: release reset, wait, then re-enable. It sits between the system power controller and one gated clock/logic domain, with all logic clocked by `clk_i`.

## Interface
- `DRAIN_TIMEOUT`, default 8: RTC ticks allowed in DRAIN before forcing progress; must be ≥1.
- `HOLD_CYCLES`, default 4: RTC ticks between enable removal (post-drain) and reset assertion; must be ≥1.
- `WAKE_CYCLES`, default 4: RTC ticks between reset release and enable assertion; must be ≥1.

Ports:
- `clk_i`  in  1  system clock; all state is on its rising edge.
- `arst_ni`  in  1  reset; asynchronous, active-low.
- `rtc_i`  in  1  asynchronous slow RTC clock; only its rising edges are used.
- `off_req_i`  in  1  level shutdown request; 1 = go/stay off.
- `idle_i`  in  1  downstream reports drained/idle.
- `en_o`  out  1  downstream enable, registered.
- `rst_no`  out  1  downstream reset, active-low, registered (0 = held in reset).
- `off_o`  out  1  high while in OFF.
- `timeout_o`  out  1  sticky flag: last DRAIN ended by timeout.
- `state_o`  out  3  current state encoding: RUN=0, DRAIN=1, HOLD=2, OFF=3, WAKE=4.

## Operation
RTC tick generation:
- `rtc_i` passes through a 2-flop synchronizer, then a previous-value register.
- `tick` = `sync2 & ~prev`: a one-`clk_i`-cycle pulse per RTC rising edge.
- All three flops reset to 0.

Tick counter:
- Width `$clog2(max(DRAIN_TIMEOUT,HOLD_CYCLES,WAKE_CYCLES)+1)`.
- Cleared on every state transition edge; increments on `tick`; saturates, never wraps.
- A tick sampled on the transition edge itself is not counted.
- "N ticks elapsed" means the edge where the N-th counted tick is sampled.

State machine (reset state OFF):
- **RUN**: `en_o`=1, `rst_no`=1. `off_req_i`=1 → DRAIN.
- **DRAIN**: `en_o`=0, `rst_no`=1. Checked in priority order:
  - `off_req_i`=0 → RUN (abort).
  - else `idle_i`=1 → HOLD.
  - else `DRAIN_TIMEOUT` ticks elapsed → HOLD and set `timeout_o`.
- **HOLD**: `en_o`=0, `rst_no`=1. `HOLD_CYCLES` ticks elapsed → OFF. Committed: `off_req_i` is ignored.
- **OFF**: `en_o`=0, `rst_no`=0, `off_o`=1. `off_req_i`=0 → WAKE.
- **WAKE**: `en_o`=0, `rst_no`=1. Checked in priority order:
  - `off_req_i`=1 → OFF.
  - else `WAKE_CYCLES` ticks elapsed → RUN.

`timeout_o`:
- Cleared on entry to DRAIN.
- Set on a timeout exit from DRAIN.
- Otherwise holds its value.

Outputs:
- `en_o`, `rst_no` and `off_o` are registered decodes of the next state, so they change on the same edge as the state.
- No output glitches.

## Timing
- Reset values: state OFF, `en_o`=0, `rst_no`=0, `off_o`=1, `timeout_o`=0, `state_o`=3, counter 0, sync flops 0.
- On `arst_ni` release with `off_req_i`=0: WAKE is entered on the first `clk_i` edge, and `rst_no`=1 from that edge.
- `rtc_i` rising edge to `tick` high: 2 `clk_i` edges (synchronizer), plus 0 to 1 cycle of sampling uncertainty. `tick` is high for exactly 1 cycle.
- `off_req_i` sampled high in RUN: `en_o` falls on that same edge.
- `idle_i` to HOLD: 1 edge. It may be high on the DRAIN entry edge+1, so the minimum DRAIN stay is 1 cycle.
- `rtc_i` must be slower than `clk_i`/4. A faster `rtc_i` is outside spec.
- `arst_ni` asserted mid-sequence: the block goes to OFF immediately and asynchronously, with `rst_no`=0 and `en_o`=0.
- `off_req_i` toggling in HOLD has no effect. Toggling in OFF/WAKE follows the priorities above, with no intermediate RUN.

## Test plan
Common setup: `DRAIN_TIMEOUT`=4, `HOLD_CYCLES`=2, `WAKE_CYCLES`=3, `rtc_i` period 16 clk.

1. Reset release, `off_req_i`=0:
   - `rst_no`=1 one edge after release.
   - `en_o`=1 after the 3rd tick.
   - `state_o` sequence 3→4→0.
2. RUN, `off_req_i`=1, `idle_i`=1 two cycles later:
   - `en_o` falls on the request edge.
   - HOLD is entered 1 edge after `idle_i` is sampled.
   - `rst_no` falls on the 2nd tick; `off_o`=1; `timeout_o`=0.
3. RUN, `off_req_i`=1, `idle_i` held 0:
   - HOLD is entered on the 4th tick with `timeout_o`=1.
   - OFF follows after 2 more ticks.
   - `timeout_o` stays 1 until the next DRAIN entry.
4. Abort in DRAIN: `off_req_i` 1→0 before `idle_i` → return to RUN, `en_o`=1 on the next edge, `rst_no` never falls.
5. Request withdrawn and re-raised:
   - In OFF, `off_req_i`=0 → WAKE.
   - `off_req_i`=1 after 1 tick → OFF, `rst_no`=0 on the next edge, `en_o` stays 0.
   - `off_req_i` toggled during HOLD → ignored, OFF still reached.
6. `arst_ni` pulsed low in WAKE, DRAIN, and HOLD → every case shows `en_o`=0, `rst_no`=0, `state_o`=3 immediately, and the counter is reset.

Source files
------------

// File: rtl/pwr_down_seq.sv
// Power-down / re-wake sequencer for one gated domain.
// Shutdown removes the enable, drains with a timeout, settles, then resets; wake reverses this.
module pwr_down_seq #(
  parameter int unsigned DRAIN_TIMEOUT = 8,
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned WAKE_CYCLES   = 4
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic       rtc_i,
  input  logic       off_req_i,
  input  logic       idle_i,
  output logic       en_o,
  output logic       rst_no,
  output logic       off_o,
  output logic       timeout_o,
  output logic [2:0] state_o
);

  localparam int unsigned MaxAb     = (DRAIN_TIMEOUT > HOLD_CYCLES) ? DRAIN_TIMEOUT : HOLD_CYCLES;
  localparam int unsigned MaxCycles = (MaxAb > WAKE_CYCLES) ? MaxAb : WAKE_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] CntMax     = {CntW{1'b1}};
  localparam logic [CntW-1:0] DrainLast  = CntW'(DRAIN_TIMEOUT - 1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] WakeLast   = CntW'(WAKE_CYCLES - 1);

  typedef enum logic [2:0] {
    StRun   = 3'd0,
    StDrain = 3'd1,
    StHold  = 3'd2,
    StOff   = 3'd3,
    StWake  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rtc_sync1_q, rtc_sync2_q, rtc_prev_q;
  logic            tick;
  logic            drain_timeout;
  logic            en_q, en_d;
  logic            rst_n_q, rst_n_d;
  logic            off_q, off_d;
  logic            timeout_q, timeout_d;

  // RTC edge detect: 2-flop synchronizer plus previous-value register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rtc_sync1_q <= 1'b0;
      rtc_sync2_q <= 1'b0;
      rtc_prev_q  <= 1'b0;
    end else begin
      rtc_sync1_q <= rtc_i;
      rtc_sync2_q <= rtc_sync1_q;
      rtc_prev_q  <= rtc_sync2_q;
    end
  end

  assign tick = rtc_sync2_q & ~rtc_prev_q;

  // State register, tick counter and registered output decodes.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= StOff;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      rst_n_q   <= 1'b0;
      off_q     <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      rst_n_q   <= rst_n_d;
      off_q     <= off_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic; a transition fires on the edge sampling the N-th counted tick.
  always_comb begin
    state_d       = state_q;
    drain_timeout = 1'b0;
    unique case (state_q)
      StRun: begin
        if (off_req_i) state_d = StDrain;
      end
      StDrain: begin
        if (!off_req_i) begin
          state_d = StRun;
        end else if (idle_i) begin
          state_d = StHold;
        end else if (tick && (cnt_q == DrainLast)) begin
          state_d       = StHold;
          drain_timeout = 1'b1;
        end
      end
      StHold: begin
        if (tick && (cnt_q == HoldLast)) state_d = StOff;
      end
      StOff: begin
        if (!off_req_i) state_d = StWake;
      end
      StWake: begin
        if (off_req_i) begin
          state_d = StOff;
        end else if (tick && (cnt_q == WakeLast)) begin
          state_d = StRun;
        end
      end
      default: state_d = StOff;
    endcase
  end

  // Counter and output next values; ticks on a transition edge are dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end

    en_d    = (state_d == StRun);
    rst_n_d = (state_d != StOff);
    off_d   = (state_d == StOff);

    timeout_d = timeout_q;
    if ((state_d == StDrain) && (state_q != StDrain)) begin
      timeout_d = 1'b0;
    end else if (drain_timeout) begin
      timeout_d = 1'b1;
    end
  end

  assign en_o      = en_q;
  assign rst_no    = rst_n_q;
  assign off_o     = off_q;
  assign timeout_o = timeout_q;
  assign state_o   = state_q;

  tick_single_cycle: assert property (@(posedge clk_i) disable iff (!arst_ni) tick |=> !tick);
  en_implies_out_of_reset: assert property (@(posedge clk_i) disable iff (!arst_ni)
                                            en_q |-> rst_n_q);

endmodule
